// File: rtl/switch_output_arbiter.sv
// switch_output_arbiter
//   Per-output-port switch arbiter sitting directly upstream of one router
//   output unit. Picks one of N_IN input units round-robin when a head flit
//   targets this output, then holds that input for the whole packet
//   (wormhole lock, HEAD..TAIL). Each flit is offered to the output unit
//   over a req/ack handshake, and the source buffer is popped on ack.
//
//   Flit type lives in bits [FLIT_W-1:FLIT_W-2]:
//     01 HEAD, 00 BODY, 10 TAIL, 11 HEAD_TAIL
//   so bit FLIT_W-2 marks "starts a packet" and bit FLIT_W-1 marks "ends a packet".
//
// Ports
//   clk           clock, rising edge
//   reset_n       asynchronous active-low reset
//   i_req         per input: a valid flit routed to this output is waiting
//   i_flit        flit of input i at [i*FLIT_W +: FLIT_W]
//   o_pop         one-hot, single cycle: input i's flit was consumed
//   o_switch_req  o_flit is valid and requests traversal
//   o_flit        flit offered to the output unit
//   i_switch_ack  output unit accepted o_flit
//   o_locked      output is owned by a packet
//   o_owner       index of the owning input (meaningful while o_locked)
//   o_proto_err   sticky protocol error, cleared only by reset
//
// State      | meaning
// -----------+----------------------------------------------------------
// IDLE       | no owner; arbitrate among head flits each cycle
// REQ        | flit held in o_flit, o_switch_req high, waiting for ack
// WAIT_NEXT  | packet still open; waiting for owner's next flit

module switch_output_arbiter #(
  parameter int N_IN   = 5,
  parameter int FLIT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_IN-1:0]          i_req,
  input  logic [N_IN*FLIT_W-1:0]   i_flit,
  output logic [N_IN-1:0]          o_pop,
  output logic                     o_switch_req,
  output logic [FLIT_W-1:0]        o_flit,
  input  logic                     i_switch_ack,
  output logic                     o_locked,
  output logic [$clog2(N_IN)-1:0]  o_owner,
  output logic                     o_proto_err
);

  localparam int OW = $clog2(N_IN);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_NEXT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [FLIT_W-1:0]   flit_q, flit_d;
  logic                err_q, err_d;

  logic [N_IN-1:0]     is_head;
  logic [N_IN-1:0]     cand;
  logic                win_vld;
  logic [OW-1:0]       win_idx;
  logic [FLIT_W-1:0]   win_flit;
  logic [FLIT_W-1:0]   own_flit;
  logic                own_req;
  logic                own_head;

  always_comb begin
    is_head = '0;
    for (int i = 0; i < N_IN; i++) begin
      is_head[i] = i_flit[i*FLIT_W + FLIT_W - 2];
    end
  end

  assign cand = i_req & is_head;

  // Scan ptr+1, ptr+2, ... so the last packet's owner gets lowest priority.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= N_IN; k++) begin
      idx = (int'(ptr_q) + k) % N_IN;
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_idx = OW'(idx);
      end
    end
  end

  always_comb begin
    win_flit = '0;
    own_flit = '0;
    own_req  = 1'b0;
    own_head = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (win_idx == OW'(i)) begin
        win_flit = i_flit[i*FLIT_W +: FLIT_W];
      end
      if (owner_q == OW'(i)) begin
        own_flit = i_flit[i*FLIT_W +: FLIT_W];
        own_req  = i_req[i];
        own_head = is_head[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (win_vld) state_d = REQ;
      REQ:       if (i_switch_ack) state_d = flit_q[FLIT_W-1] ? IDLE : WAIT_NEXT;
      WAIT_NEXT: if (own_req) state_d = REQ;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= OW'(N_IN - 1);
      owner_q <= '0;
      flit_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      flit_q  <= flit_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    flit_d  = flit_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // A BODY/TAIL at the head of a queue with no open packet is a
        // protocol violation upstream; it is never granted.
        if (|(i_req & ~is_head)) err_d = 1'b1;
        if (win_vld) begin
          owner_d = win_idx;
          flit_d  = win_flit;
        end
      end
      REQ: begin
        if (i_switch_ack && flit_q[FLIT_W-1]) ptr_d = owner_q;
      end
      WAIT_NEXT: begin
        // A new head inside an open packet is flagged but still forwarded.
        if (own_req) begin
          flit_d = own_flit;
          if (own_head) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    o_pop        = '0;
    o_switch_req = (state_q == REQ);
    o_locked     = (state_q != IDLE);
    if ((state_q == REQ) && i_switch_ack) begin
      o_pop = N_IN'(1) << owner_q;
    end
  end

  assign o_flit      = flit_q;
  assign o_owner     = owner_q;
  assign o_proto_err = err_q;

endmodule

// File: tb/tb_switch_output_arbiter.sv
module tb_switch_output_arbiter;

  localparam int N_IN   = 5;
  localparam int FLIT_W = 32;
  localparam int OW     = $clog2(N_IN);

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [N_IN-1:0]        i_req = '0;
  logic [N_IN*FLIT_W-1:0] i_flit = '0;
  logic [N_IN-1:0]        o_pop;
  logic                   o_switch_req;
  logic [FLIT_W-1:0]      o_flit;
  logic                   i_switch_ack = 1'b0;
  logic                   o_locked;
  logic [OW-1:0]          o_owner;
  logic                   o_proto_err;

  switch_output_arbiter #(.N_IN(N_IN), .FLIT_W(FLIT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_req        (i_req),
    .i_flit       (i_flit),
    .o_pop        (o_pop),
    .o_switch_req (o_switch_req),
    .o_flit       (o_flit),
    .i_switch_ack (i_switch_ack),
    .o_locked     (o_locked),
    .o_owner      (o_owner),
    .o_proto_err  (o_proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Source buffers: flat flit queues per input, packets back to back.
  logic [FLIT_W-1:0] src_q[N_IN][$];

  typedef struct {
    int                owner;
    logic [FLIT_W-1:0] flit;
  } exp_t;
  exp_t exp_q[$];
  int   m_ptr;

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [FLIT_W-1:0] p);
    return {t, p[FLIT_W-3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req        = '0;
    i_flit       = '0;
    i_switch_ack = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_ptr   = N_IN - 1;
  endtask

  // Delivery order follows from the arbitration rule alone: every waiting
  // input shows a head, so each packet goes to the next non-empty input
  // after the previous owner, modulo N_IN.
  task automatic predict();
    int pos[N_IN];
    int idx;
    bit found;
    logic [FLIT_W-1:0] f;
    exp_t e;
    foreach (pos[i]) pos[i] = 0;
    idx = 0;
    while (1) begin
      found = 1'b0;
      for (int k = 1; k <= N_IN && !found; k++) begin
        idx = (m_ptr + k) % N_IN;
        if (pos[idx] < src_q[idx].size()) found = 1'b1;
      end
      if (!found) break;
      do begin
        f = src_q[idx][pos[idx]];
        pos[idx]++;
        e.owner = idx;
        e.flit  = f;
        exp_q.push_back(e);
      end while (!f[FLIT_W-1]);
      m_ptr = idx;
    end
  endtask

  task automatic load_packet(input int src, input int len);
    logic [FLIT_W-1:0] p;
    for (int j = 0; j < len; j++) begin
      p = $urandom;
      if (len == 1)          src_q[src].push_back(mk(T_HT, p));
      else if (j == 0)       src_q[src].push_back(mk(T_HEAD, p));
      else if (j == len - 1) src_q[src].push_back(mk(T_TAIL, p));
      else                   src_q[src].push_back(mk(T_BODY, p));
    end
  endtask

  task automatic run_stream(input int max_cycles);
    logic [N_IN-1:0]   pops;
    logic [FLIT_W-1:0] front;
    int   cyc;
    int   left;
    exp_t e;
    predict();
    pops = '0;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      tick();
      for (int i = 0; i < N_IN; i++) begin
        if (pops[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      for (int i = 0; i < N_IN; i++) begin
        if (src_q[i].size() > 0) begin
          front = src_q[i][0];
          i_flit[i*FLIT_W +: FLIT_W] = front;
          // only non-head flits may be late; heads wait steadily
          i_req[i] = front[FLIT_W-2] || ($urandom_range(0, 2) != 0);
        end else begin
          i_flit[i*FLIT_W +: FLIT_W] = '0;
          i_req[i] = 1'b0;
        end
      end
      i_switch_ack = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      pops = o_pop;
      if (o_switch_req && i_switch_ack) begin
        e = exp_q.pop_front();
        check("owner", 64'(o_owner), 64'(e.owner));
        check("flit", 64'(o_flit), 64'(e.flit));
        check("pop", 64'(o_pop), 64'(1) << e.owner);
        check("locked", 64'(o_locked), 64'd1);
      end else begin
        check("no_pop", 64'(o_pop), 64'd0);
      end
      cyc++;
    end
    check("stream_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick();
    for (int i = 0; i < N_IN; i++) begin
      if (pops[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    left = 0;
    for (int i = 0; i < N_IN; i++) begin
      left += src_q[i].size();
      src_q[i].delete();
    end
    i_req        = '0;
    i_switch_ack = 1'b0;
    @(negedge clk);
    check("drained", 64'(left), 64'd0);
    check("idle_unlocked", 64'(o_locked), 64'd0);
    check("stream_no_err", 64'(o_proto_err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FLIT_W-1:0] f1, f4, h1, h2;

    // Reset state
    m_ptr = N_IN - 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pop", 64'(o_pop), 64'd0);
    check("rst_sreq", 64'(o_switch_req), 64'd0);
    check("rst_flit", 64'(o_flit), 64'd0);
    check("rst_locked", 64'(o_locked), 64'd0);
    check("rst_owner", 64'(o_owner), 64'd0);
    check("rst_err", 64'(o_proto_err), 64'd0);
    do_reset();

    // Single-flit packet, request latency, ack two cycles after request
    f1 = mk(T_HT, 32'h1234_5678);
    i_req = 5'b00001;
    i_flit[0 +: FLIT_W] = f1;
    @(negedge clk);
    check("t1_sreq_t", 64'(o_switch_req), 64'd0);
    tick();
    @(negedge clk);
    check("t1_sreq_t1", 64'(o_switch_req), 64'd1);
    check("t1_flit", 64'(o_flit), 64'(f1));
    check("t1_owner", 64'(o_owner), 64'd0);
    check("t1_locked", 64'(o_locked), 64'd1);
    tick();
    @(negedge clk);
    check("t1_no_pop", 64'(o_pop), 64'd0);
    tick();
    i_switch_ack = 1'b1;
    @(negedge clk);
    check("t1_pop", 64'(o_pop), 64'b00001);
    tick();
    i_req = '0;
    i_switch_ack = 1'b0;
    @(negedge clk);
    check("t1_unlocked", 64'(o_locked), 64'd0);
    // ptr is now 0: input 1 must beat input 0
    i_req = 5'b00011;
    i_flit[FLIT_W +: FLIT_W] = mk(T_HT, 32'h0000_0011);
    tick();
    i_switch_ack = 1'b1;
    @(negedge clk);
    check("t1_ptr_owner", 64'(o_owner), 64'd1);
    check("t1_ptr_pop", 64'(o_pop), 64'b00010);
    tick();
    i_req = 5'b00001;
    i_switch_ack = 1'b0;
    tick();
    i_switch_ack = 1'b1;
    @(negedge clk);
    check("t1_next_owner", 64'(o_owner), 64'd0);
    check("t1_next_pop", 64'(o_pop), 64'b00001);
    tick();
    i_req = '0;
    i_switch_ack = 1'b0;

    // Wrap-around with backpressure: ptr=4, inputs 4 and 1 request
    do_reset();
    f1 = mk(T_HT, 32'h0000_0101);
    f4 = mk(T_HT, 32'h0000_0404);
    i_flit[1*FLIT_W +: FLIT_W] = f1;
    i_flit[4*FLIT_W +: FLIT_W] = f4;
    i_flit[3*FLIT_W +: FLIT_W] = mk(T_HEAD, 32'h0000_0303);
    i_req = 5'b10010;
    tick();
    for (int c = 0; c < 10; c++) begin
      i_req[3] = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_sreq", 64'(o_switch_req), 64'd1);
      check("bp_flit", 64'(o_flit), 64'(f1));
      check("bp_pop", 64'(o_pop), 64'd0);
      tick();
    end
    i_switch_ack = 1'b1;
    @(negedge clk);
    check("wrap_owner1", 64'(o_owner), 64'd1);
    check("wrap_pop1", 64'(o_pop), 64'b00010);
    tick();
    i_req = 5'b10000;
    i_switch_ack = 1'b0;
    tick();
    i_switch_ack = 1'b1;
    @(negedge clk);
    check("wrap_owner4", 64'(o_owner), 64'd4);
    check("wrap_flit4", 64'(o_flit), 64'(f4));
    check("wrap_pop4", 64'(o_pop), 64'b10000);
    tick();
    i_req = '0;
    i_switch_ack = 1'b0;

    // Round-robin fairness between inputs 0 and 3
    do_reset();
    for (int j = 0; j < 3; j++) begin
      load_packet(0, 1);
      load_packet(3, 1);
    end
    run_stream(500);

    // Wormhole lock: input 2 sends H,B,B,T while input 0 keeps a head waiting
    do_reset();
    load_packet(0, 1);
    load_packet(0, 1);
    load_packet(2, 4);
    run_stream(500);

    // Randomized traffic, pointer carried across streams
    do_reset();
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < N_IN; i++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) load_packet(i, $urandom_range(1, 4));
      end
      load_packet($urandom_range(0, N_IN - 1), $urandom_range(1, 4));
      run_stream(2000);
    end

    // HEAD from the owner in WAIT_NEXT: flagged and forwarded
    do_reset();
    h1 = mk(T_HEAD, 32'h0000_0aa2);
    h2 = mk(T_HEAD, 32'h0000_0bb2);
    i_flit[2*FLIT_W +: FLIT_W] = h1;
    i_req = 5'b00100;
    tick();
    i_switch_ack = 1'b1;
    @(negedge clk);
    check("wn_pop", 64'(o_pop), 64'b00100);
    tick();
    i_req = '0;
    i_switch_ack = 1'b0;
    @(negedge clk);
    check("wn_err_before", 64'(o_proto_err), 64'd0);
    check("wn_wait_sreq", 64'(o_switch_req), 64'd0);
    tick();
    i_flit[2*FLIT_W +: FLIT_W] = h2;
    i_req = 5'b00100;
    tick();
    @(negedge clk);
    check("wn_fwd_sreq", 64'(o_switch_req), 64'd1);
    check("wn_fwd_flit", 64'(o_flit), 64'(h2));
    check("wn_fwd_owner", 64'(o_owner), 64'd2);
    check("wn_err_after", 64'(o_proto_err), 64'd1);

    // Asynchronous reset mid-packet, with an ack on the wire
    tick();
    i_switch_ack = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pop", 64'(o_pop), 64'd0);
    check("arst_sreq", 64'(o_switch_req), 64'd0);
    check("arst_flit", 64'(o_flit), 64'd0);
    check("arst_locked", 64'(o_locked), 64'd0);
    check("arst_owner", 64'(o_owner), 64'd0);
    check("arst_err", 64'(o_proto_err), 64'd0);
    i_req = '0;
    i_switch_ack = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // BODY in IDLE: error, no grant, sticky until reset
    i_flit[2*FLIT_W +: FLIT_W] = mk(T_BODY, 32'h0000_0cc2);
    i_req = 5'b00100;
    tick();
    @(negedge clk);
    check("body_err", 64'(o_proto_err), 64'd1);
    check("body_sreq", 64'(o_switch_req), 64'd0);
    check("body_locked", 64'(o_locked), 64'd0);
    i_req = '0;
    tick();
    tick();
    @(negedge clk);
    check("err_sticky", 64'(o_proto_err), 64'd1);
    reset_n = 1'b0;
    #1;
    check("err_cleared", 64'(o_proto_err), 64'd0);
    #5;
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
